config_serial_loader: RTL and testbench

- Upstream configuration-bus master for the tile array; drives the shared config_addr/config_data bus that the IO and PE tiles decode every cycle.
- Deserialises a 64-bit frame from a bit-serial host link, then presents it as one bus write for a fixed number of cycles.
- Between writes, parks the bus on a non-matching address so no tile captures data.

---
 rtl/config_serial_loader.sv | 131 +++++++++++++
 tb/tb_config_serial_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_serial_loader.sv
// Configuration-bus master: deserialises 64-bit {addr, data} frames from a
// bit-serial host link and drives each one onto the tile config bus as a held write.
module config_serial_loader #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdi,
    input  logic        shift_en,
    input  logic        latch,
    input  logic        err_clr,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun,
    output logic [15:0] write_count
);

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_DRIVE,
        ST_GAP
    } state_e;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

    state_e      state_q,     state_d;
    logic [63:0] shift_q,     shift_d;
    logic [6:0]  cnt_q,       cnt_d;
    logic [3:0]  hold_q,      hold_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] data_q,      data_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q,   overrun_d;
    logic [15:0] wcount_q,    wcount_d;
    logic        frame_err_set;
    logic        overrun_set;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SHIFT;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            addr_q      <= IDLE_ADDR;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wcount_q    <= wcount_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wcount_d      = wcount_q;
        frame_err_set = 1'b0;
        overrun_set   = 1'b0;

        unique case (state_q)
            ST_SHIFT: begin
                // latch takes priority over a coincident shift; count is judged pre-shift
                if (latch) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    if (cnt_q == 7'd64) begin
                        addr_d  = shift_q[63:32];
                        data_d  = shift_q[31:0];
                        hold_d  = HOLD_INIT;
                        state_d = ST_DRIVE;
                    end else begin
                        frame_err_set = 1'b1;
                    end
                end else if (shift_en) begin
                    shift_d = {shift_q[62:0], sdi};
                    if (cnt_q != 7'd127) begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_DRIVE: begin
                overrun_set = shift_en | latch;
                if (hold_q == 4'd0) begin
                    addr_d   = IDLE_ADDR;
                    data_d   = '0;
                    wcount_d = wcount_q + 16'd1;
                    state_d  = ST_GAP;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            ST_GAP: begin
                overrun_set = shift_en | latch;
                state_d     = ST_SHIFT;
            end
            default: state_d = ST_SHIFT;
        endcase

        // sticky flags: a new error in the same cycle as err_clr is kept
        frame_err_d = frame_err_set | (frame_err_q & ~err_clr);
        overrun_d   = overrun_set   | (overrun_q   & ~err_clr);
    end

    assign config_addr = addr_q;
    assign config_data = data_q;
    assign busy        = (state_q != ST_SHIFT);
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign write_count = wcount_q;

endmodule

// File: tb/tb_config_serial_loader.sv
// Directed self-checking bench for config_serial_loader (HOLD_CYCLES=2),
// with a one-bit IO tile model (tile_id 3) listening on the config bus.
module tb_config_serial_loader;

    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        sdi;
    logic        shift_en;
    logic        latch;
    logic        err_clr;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        frame_err;
    logic        overrun;
    logic [15:0] write_count;
    logic        io_bit;

    int n_checks = 0;
    int n_fail   = 0;

    config_serial_loader #(
        .HOLD_CYCLES(2),
        .IDLE_ADDR  (32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sdi        (sdi),
        .shift_en   (shift_en),
        .latch      (latch),
        .err_clr    (err_clr),
        .config_addr(config_addr),
        .config_data(config_data),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // io1bit tile: feature 0, tile_id 3, captures data bit 0 on address match
    always @(posedge clk) begin
        if (reset) begin
            io_bit <= 1'b0;
        end else if (config_addr[23:16] == 8'h00 && config_addr[15:0] == 16'h0003) begin
            io_bit <= config_data[0];
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; after cyc() the next rising edge has sampled them.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic shift_bits(input logic [63:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            shift_en = 1'b1;
            sdi      = (i < 64) ? f[63 - i] : 1'b1;
            cyc();
        end
        shift_en = 1'b0;
        sdi      = 1'b0;
    endtask

    task automatic pulse_latch();
        latch = 1'b1;
        cyc();
        latch = 1'b0;
    endtask

    task automatic write_frame(input logic [63:0] f);
        shift_bits(f, 64);
        pulse_latch();
    endtask

    initial begin
        reset    = 1'b1;
        sdi      = 1'b0;
        shift_en = 1'b0;
        latch    = 1'b0;
        err_clr  = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (10) cyc();

        // reset / idle state
        check("rst_addr",   config_addr,         IDLE);
        check("rst_data",   config_data,         32'd0);
        check("rst_busy",   32'(busy),           32'd0);
        check("rst_ferr",   32'(frame_err),      32'd0);
        check("rst_ovr",    32'(overrun),        32'd0);
        check("rst_wcount", 32'(write_count),    32'd0);

        // basic write: bus shows frame for 2 cycles, then one idle cycle while busy
        write_frame(64'h0000_0003_0000_0001);
        check("w1_addr0", config_addr, 32'h0000_0003);
        check("w1_data0", config_data, 32'h0000_0001);
        check("w1_busy0", 32'(busy),   32'd1);
        cyc();
        check("w1_addr1", config_addr, 32'h0000_0003);
        check("w1_data1", config_data, 32'h0000_0001);
        check("w1_busy1", 32'(busy),   32'd1);
        cyc();
        check("w1_gap_addr", config_addr,      IDLE);
        check("w1_gap_data", config_data,      32'd0);
        check("w1_gap_busy", 32'(busy),        32'd1);
        check("w1_wcount",   32'(write_count), 32'd1);
        cyc();
        check("w1_busy_end", 32'(busy),   32'd0);
        check("w1_io_bit",   32'(io_bit), 32'd1);

        // short frame (63 bits): error, no bus activity
        shift_bits(64'hFFFF_FFFF_FFFF_FFFF, 63);
        pulse_latch();
        check("short_ferr", 32'(frame_err), 32'd1);
        check("short_addr", config_addr,    IDLE);
        check("short_busy", 32'(busy),      32'd0);

        // good frame after error: count was cleared, flag stays sticky
        write_frame(64'h0000_0105_DEAD_BEEF);
        check("w2_addr", config_addr,    32'h0000_0105);
        check("w2_data", config_data,    32'hDEAD_BEEF);
        check("w2_ferr", 32'(frame_err), 32'd1);
        repeat (3) cyc();
        check("w2_busy_end", 32'(busy),        32'd0);
        check("w2_wcount",   32'(write_count), 32'd2);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("clr1_ferr", 32'(frame_err), 32'd0);

        // long frame (70 bits): error; set beats a coincident clear
        shift_bits(64'h0, 70);
        pulse_latch();
        check("long_ferr", 32'(frame_err), 32'd1);
        check("long_busy", 32'(busy),      32'd0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("clr2_ferr", 32'(frame_err), 32'd0);
        latch   = 1'b1;
        err_clr = 1'b1;
        cyc();
        latch   = 1'b0;
        err_clr = 1'b0;
        check("setwins_ferr", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("clr3_ferr", 32'(frame_err), 32'd0);

        // latch with shift in the same cycle: latch wins, shift dropped
        shift_bits(64'h0000_0007_0000_00A5, 64);
        latch    = 1'b1;
        shift_en = 1'b1;
        sdi      = 1'b1;
        cyc();
        latch    = 1'b0;
        shift_en = 1'b0;
        sdi      = 1'b0;
        check("lw_addr", config_addr,    32'h0000_0007);
        check("lw_data", config_data,    32'h0000_00A5);
        check("lw_ferr", 32'(frame_err), 32'd0);
        repeat (3) cyc();
        check("lw_wcount", 32'(write_count), 32'd3);

        // latch + shift during DRIVE: overrun, no second write, shifter untouched
        write_frame(64'h0000_0010_1234_5678);
        latch    = 1'b1;
        shift_en = 1'b1;
        sdi      = 1'b1;
        cyc();
        latch    = 1'b0;
        shift_en = 1'b0;
        sdi      = 1'b0;
        check("ovr_flag", 32'(overrun),   32'd1);
        check("ovr_addr", config_addr,    32'h0000_0010);
        cyc();
        check("ovr_wcount", 32'(write_count), 32'd4);
        repeat (3) cyc();
        check("ovr_busy",    32'(busy),        32'd0);
        check("ovr_idle",    config_addr,      IDLE);
        check("ovr_wcount2", 32'(write_count), 32'd4);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        write_frame(64'h0000_0020_0000_0055);
        check("post_ovr_addr", config_addr,    32'h0000_0020);
        check("post_ovr_ferr", 32'(frame_err), 32'd0);
        repeat (3) cyc();
        check("post_ovr_wcount", 32'(write_count), 32'd5);

        // reset in the first DRIVE cycle aborts the write
        write_frame(64'h0000_0030_CAFE_F00D);
        check("abort_pre_addr", config_addr, 32'h0000_0030);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort_addr",   config_addr,         IDLE);
        check("abort_data",   config_data,         32'd0);
        check("abort_busy",   32'(busy),           32'd0);
        check("abort_wcount", 32'(write_count),    32'd0);
        repeat (3) cyc();
        check("abort_idle", config_addr, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
